// File: rtl/match_capture.sv
// Match capture for the MD5 search pipeline: holds a 128-bit target, flags the first matching
// candidate and drains in-flight results after the sweep ends. Define HIT_COUNT_EN to count matches.
module match_capture #(
  parameter logic [7:0] DRAIN_CYCLES = 8'd64
) (
  input  logic         CLK,
  input  logic         reset_n,
  input  logic         arm,
  input  logic         target_we,
  input  logic [1:0]   target_idx,
  input  logic [31:0]  target_word,
  input  logic         hash_valid,
  input  logic [127:0] hash_in,
  input  logic [31:0]  counter_in,
  input  logic         sweep_done,
  output logic         found,
  output logic [31:0]  match_counter,
  output logic [2:0]   state,
  output logic         busy,
  output logic [15:0]  hit_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARMED     = 3'd1,
    S_DRAIN     = 3'd2,
    S_FOUND     = 3'd3,
    S_EXHAUSTED = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [127:0]   target_q, target_d;
  logic           match_r_q, match_r_d;
  logic [31:0]    cand_r_q, cand_r_d;
  logic [31:0]    match_cnt_q, match_cnt_d;
  logic           found_q, found_d;
  logic [7:0]     drain_q, drain_d;

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      target_q    <= '0;
      match_r_q   <= 1'b0;
      cand_r_q    <= '0;
      match_cnt_q <= '0;
      found_q     <= 1'b0;
      drain_q     <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      match_r_q   <= match_r_d;
      cand_r_q    <= cand_r_d;
      match_cnt_q <= match_cnt_d;
      found_q     <= found_d;
      drain_q     <= drain_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    match_r_d   = hash_valid && (hash_in == target_q);
    cand_r_d    = counter_in;
    match_cnt_d = match_cnt_q;
    found_d     = found_q;
    drain_d     = drain_q;

    if (state_q == S_IDLE && target_we) begin
      case (target_idx)
        2'd0:    target_d[127:96] = target_word;
        2'd1:    target_d[95:64]  = target_word;
        2'd2:    target_d[63:32]  = target_word;
        default: target_d[31:0]   = target_word;
      endcase
    end

    if (arm) begin
      state_d     = S_ARMED;
      found_d     = 1'b0;
      match_cnt_d = '0;
      drain_d     = '0;
      match_r_d   = 1'b0;
      cand_r_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ARMED: begin
          if (match_r_q) begin
            state_d     = S_FOUND;
            found_d     = 1'b1;
            match_cnt_d = cand_r_q;
          end else if (sweep_done) begin
            state_d = S_DRAIN;
            drain_d = DRAIN_CYCLES;
          end
        end
        S_DRAIN: begin
          if (match_r_q) begin
            state_d     = S_FOUND;
            found_d     = 1'b1;
            match_cnt_d = cand_r_q;
          // Exit when this cycle consumes the last count; a zero load exits immediately.
          end else if (drain_q <= 8'd1) begin
            state_d = S_EXHAUSTED;
            drain_d = '0;
          end else begin
            drain_d = drain_q - 8'd1;
          end
        end
        S_FOUND, S_EXHAUSTED: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

`ifdef HIT_COUNT_EN
  logic [15:0] hit_q, hit_d;

  always_ff @(posedge CLK) begin
    if (!reset_n) hit_q <= '0;
    else          hit_q <= hit_d;
  end

  always_comb begin
    hit_d = hit_q;
    if (arm) begin
      hit_d = '0;
    end else if (match_r_q && hit_q != '1 &&
                 (state_q == S_ARMED || state_q == S_DRAIN || state_q == S_FOUND)) begin
      hit_d = hit_q + 16'd1;
    end
  end

  assign hit_count = hit_q;
`else
  assign hit_count = '0;
`endif

  assign found         = found_q;
  assign match_counter = match_cnt_q;
  assign state         = state_q;
  assign busy          = (state_q == S_ARMED) || (state_q == S_DRAIN);

endmodule
